// File: rtl/operand_fetch.sv
// operand_fetch: the ID/EX boundary stage of an RV32I pipeline.
//
// Purpose:
//   - Drives the register file read addresses straight from decode.
//   - Resolves each source operand by bypass priority:
//     x0, then EX, then MEM, then WB, then the register file.
//   - Detects load-use hazards. On a hazard it stalls decode and
//     inserts a single bubble into EX.
//   - Registers the resolved operands and pass-through control into EX.
//   - Supports stall and flush.
//   - Counts inserted load-use bubbles in a saturating counter.
//
// Ports:
//   clk, reset                        clock; asynchronous active-high reset
//   id_*                              decoded instruction from ID
//   rf_rs1_addr/rf_rs2_addr (out)     register file read addresses (combinational)
//   rf_rs1_data/rf_rs2_data (in)      register file asynchronous read data
//   ex_alu_result                     EX result of the instruction held in ex_*
//   mem_fwd_we/rd/value               MEM-stage forwarding source
//   wb_we/wb_addr/wb_value            register file write port this cycle
//   ex_stall                          downstream holds EX
//   flush                             kill the EX-bound instruction
//   id_stall (out)                    decode/fetch must hold (combinational)
//   ex_* (out)                        registered instruction presented to EX
//   load_use_cnt (out)                saturating count of load-use bubbles

module operand_fetch #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic [31:0]      id_imm,
    input  logic [31:0]      id_pc,
    input  logic [15:0]      id_ctrl,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [31:0]      rf_rs1_data,
    input  logic [31:0]      rf_rs2_data,
    input  logic [31:0]      ex_alu_result,
    input  logic             mem_fwd_we,
    input  logic [4:0]       mem_fwd_rd,
    input  logic [31:0]      mem_fwd_value,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_value,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [31:0]      ex_rs1_value,
    output logic [31:0]      ex_rs2_value,
    output logic [4:0]       ex_rd_addr,
    output logic             ex_rd_we,
    output logic             ex_is_load,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc,
    output logic [15:0]      ex_ctrl,
    output logic [CNT_W-1:0] load_use_cnt
);

    logic             ex_valid_q;
    logic [31:0]      ex_rs1_value_q;
    logic [31:0]      ex_rs2_value_q;
    logic [4:0]       ex_rd_addr_q;
    logic             ex_rd_we_q;
    logic             ex_is_load_q;
    logic [31:0]      ex_imm_q;
    logic [31:0]      ex_pc_q;
    logic [15:0]      ex_ctrl_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             ex_fwd_en;
    logic             load_use;
    logic [31:0]      rs1_res;
    logic [31:0]      rs2_res;

    // A load in EX has no data yet. Its rd is therefore never an
    // EX-bypass source; that dependency is covered by load_use.
    assign ex_fwd_en = ex_valid_q & ex_rd_we_q & ~ex_is_load_q;

    // Shared priority chain for both source operands.
    function automatic logic [31:0] resolve(
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic        ex_en,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_value,
        input logic        mem_we,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_value,
        input logic        wbw,
        input logic [4:0]  wba,
        input logic [31:0] wbv
    );
        logic [31:0] r;
        if (rs == 5'd0)
            r = '0;
        else if (ex_en && ex_rd == rs)
            r = ex_value;
        else if (mem_we && mem_rd == rs)
            r = mem_value;
        // The register file updates only at the edge, so a same-cycle
        // write must be bypassed here.
        else if (wbw && wba == rs)
            r = wbv;
        else
            r = rf_data;
        return r;
    endfunction

    assign rf_rs1_addr = id_rs1_addr;
    assign rf_rs2_addr = id_rs2_addr;

    assign rs1_res = resolve(id_rs1_addr, rf_rs1_data, ex_fwd_en, ex_rd_addr_q, ex_alu_result,
                             mem_fwd_we, mem_fwd_rd, mem_fwd_value, wb_we, wb_addr, wb_value);
    assign rs2_res = resolve(id_rs2_addr, rf_rs2_data, ex_fwd_en, ex_rd_addr_q, ex_alu_result,
                             mem_fwd_we, mem_fwd_rd, mem_fwd_value, wb_we, wb_addr, wb_value);

    assign load_use = id_valid & ex_valid_q & ex_is_load_q & ex_rd_we_q & (ex_rd_addr_q != 5'd0) &
                      ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr_q)) |
                       (id_uses_rs2 & (id_rs2_addr == ex_rd_addr_q)));

    // A flush squashes the dependent's producer path anyway, so decode
    // is free to move on even if a hazard is also present.
    assign id_stall = (load_use | ex_stall) & ~flush;

    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_value_q <= '0;
            ex_rs2_value_q <= '0;
            ex_rd_addr_q   <= '0;
            ex_rd_we_q     <= 1'b0;
            ex_is_load_q   <= 1'b0;
            ex_imm_q       <= '0;
            ex_pc_q        <= '0;
            ex_ctrl_q      <= '0;
            cnt_q          <= '0;
        end else if (flush) begin
            ex_valid_q   <= 1'b0;
            ex_rd_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else if (!ex_stall) begin
            if (load_use) begin
                ex_valid_q   <= 1'b0;
                ex_rd_we_q   <= 1'b0;
                ex_is_load_q <= 1'b0;
                cnt_q        <= cnt_d;
            end else begin
                ex_valid_q     <= id_valid;
                ex_rs1_value_q <= rs1_res;
                ex_rs2_value_q <= rs2_res;
                ex_rd_addr_q   <= id_rd_addr;
                ex_rd_we_q     <= id_rd_we & id_valid;
                ex_is_load_q   <= id_is_load & id_valid;
                ex_imm_q       <= id_imm;
                ex_pc_q        <= id_pc;
                ex_ctrl_q      <= id_ctrl;
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_rs1_value = ex_rs1_value_q;
    assign ex_rs2_value = ex_rs2_value_q;
    assign ex_rd_addr   = ex_rd_addr_q;
    assign ex_rd_we     = ex_rd_we_q;
    assign ex_is_load   = ex_is_load_q;
    assign ex_imm       = ex_imm_q;
    assign ex_pc        = ex_pc_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign load_use_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch.
// Expected EX-stage contents are queued when the ID inputs are driven and
// checked one edge later. A second instance with a 2-bit counter shares
// the stimulus to exercise counter saturation.

module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, id_rd_we, id_is_load;
    logic [31:0] id_imm, id_pc;
    logic [15:0] id_ctrl;
    logic [31:0] rf_rs1_data, rf_rs2_data, ex_alu_result;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_value;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_value;
    logic        ex_stall, flush;

    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic        id_stall, ex_valid, ex_rd_we, ex_is_load;
    logic [31:0] ex_rs1_value, ex_rs2_value, ex_imm, ex_pc;
    logic [4:0]  ex_rd_addr;
    logic [15:0] ex_ctrl;
    logic [15:0] load_use_cnt;

    logic [4:0]  d2_rf_rs1_addr, d2_rf_rs2_addr;
    logic        d2_id_stall, d2_ex_valid, d2_ex_rd_we, d2_ex_is_load;
    logic [31:0] d2_ex_rs1_value, d2_ex_rs2_value, d2_ex_imm, d2_ex_pc;
    logic [4:0]  d2_ex_rd_addr;
    logic [15:0] d2_ex_ctrl;
    logic [1:0]  d2_load_use_cnt;

    always #5 clk = ~clk;

    operand_fetch #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_alu_result(ex_alu_result),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_value(mem_fwd_value),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_value(wb_value),
        .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_rs1_value(ex_rs1_value), .ex_rs2_value(ex_rs2_value),
        .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
        .load_use_cnt(load_use_cnt)
    );

    operand_fetch #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .rf_rs1_addr(d2_rf_rs1_addr), .rf_rs2_addr(d2_rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_alu_result(ex_alu_result),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_value(mem_fwd_value),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_value(wb_value),
        .ex_stall(ex_stall), .flush(flush), .id_stall(d2_id_stall),
        .ex_valid(d2_ex_valid), .ex_rs1_value(d2_ex_rs1_value), .ex_rs2_value(d2_ex_rs2_value),
        .ex_rd_addr(d2_ex_rd_addr), .ex_rd_we(d2_ex_rd_we), .ex_is_load(d2_ex_is_load),
        .ex_imm(d2_ex_imm), .ex_pc(d2_ex_pc), .ex_ctrl(d2_ex_ctrl),
        .load_use_cnt(d2_load_use_cnt)
    );

    typedef struct {
        logic        v, we, ld;
        logic [31:0] r1, r2, imm, pc;
        logic [4:0]  rd;
        logic [15:0] ctrl;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        bit          ctl_only;
    } exp_t;

    exp_t        sbq[$];
    exp_t        last;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [15:0] ctrl);
        id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd_addr = rd;
        id_rd_we = we; id_is_load = ld; id_imm = imm; id_pc = pc; id_ctrl = ctrl;
    endtask

    task automatic fwd_off();
        mem_fwd_we = 1'b0; mem_fwd_rd = '0; mem_fwd_value = '0;
        wb_we = 1'b0; wb_addr = '0; wb_value = '0;
        ex_alu_result = '0; rf_rs1_data = '0; rf_rs2_data = '0;
        ex_stall = 1'b0; flush = 1'b0;
    endtask

    // Combinational outputs after inputs settle.
    task automatic comb(input logic stall_exp);
        #1;
        chk("rf_rs1_addr", 32'(rf_rs1_addr), 32'(id_rs1_addr));
        chk("rf_rs2_addr", 32'(rf_rs2_addr), 32'(id_rs2_addr));
        chk("id_stall", 32'(id_stall), 32'(stall_exp));
    endtask

    task automatic push_cap(input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        e.v = id_valid; e.we = id_rd_we & id_valid; e.ld = id_is_load & id_valid;
        e.r1 = r1; e.r2 = r2; e.rd = id_rd_addr; e.imm = id_imm; e.pc = id_pc;
        e.ctrl = id_ctrl; e.cnt = m_cnt; e.cnt2 = m_cnt2; e.ctl_only = 1'b0;
        sbq.push_back(e);
        last = e;
    endtask

    task automatic push_bubble();
        exp_t e;
        if (m_cnt != 16'hFFFF) m_cnt++;
        if (m_cnt2 != 2'b11) m_cnt2++;
        e = last;
        e.v = 1'b0; e.we = 1'b0; e.ld = 1'b0;
        e.cnt = m_cnt; e.cnt2 = m_cnt2; e.ctl_only = 1'b1;
        sbq.push_back(e);
        last = e;
    endtask

    task automatic push_flush();
        exp_t e;
        e = last;
        e.v = 1'b0; e.we = 1'b0; e.ld = 1'b0; e.ctl_only = 1'b1;
        sbq.push_back(e);
        last = e;
    endtask

    task automatic push_hold();
        sbq.push_back(last);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, ".sb_depth"}, 32'(sbq.size()), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(e.v));
            chk({tag, ".ex_rd_we"}, 32'(ex_rd_we), 32'(e.we));
            chk({tag, ".ex_is_load"}, 32'(ex_is_load), 32'(e.ld));
            chk({tag, ".load_use_cnt"}, 32'(load_use_cnt), 32'(e.cnt));
            chk({tag, ".cnt2"}, 32'(d2_load_use_cnt), 32'(e.cnt2));
            chk({tag, ".d2_valid"}, 32'(d2_ex_valid), 32'(e.v));
            if (!e.ctl_only) begin
                chk({tag, ".ex_rs1_value"}, ex_rs1_value, e.r1);
                chk({tag, ".ex_rs2_value"}, ex_rs2_value, e.r2);
                chk({tag, ".ex_rd_addr"}, 32'(ex_rd_addr), 32'(e.rd));
                chk({tag, ".ex_imm"}, ex_imm, e.imm);
                chk({tag, ".ex_pc"}, ex_pc, e.pc);
                chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, ".ex_rs1_value"}, ex_rs1_value, 32'd0);
        chk({tag, ".ex_rs2_value"}, ex_rs2_value, 32'd0);
        chk({tag, ".ex_rd_addr"}, 32'(ex_rd_addr), 32'd0);
        chk({tag, ".ex_rd_we"}, 32'(ex_rd_we), 32'd0);
        chk({tag, ".ex_is_load"}, 32'(ex_is_load), 32'd0);
        chk({tag, ".ex_imm"}, ex_imm, 32'd0);
        chk({tag, ".ex_pc"}, ex_pc, 32'd0);
        chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'd0);
        chk({tag, ".load_use_cnt"}, 32'(load_use_cnt), 32'd0);
        chk({tag, ".cnt2"}, 32'(d2_load_use_cnt), 32'd0);
    endtask

    initial begin
        m_cnt = '0; m_cnt2 = '0;
        last = '{default: '0};

        // Reset with random inputs: outputs are zero before any clock edge.
        reset = 1'b1;
        drv(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom), 1'b1, 1'($urandom),
            $urandom, $urandom, 16'($urandom));
        rf_rs1_data = $urandom; rf_rs2_data = $urandom; ex_alu_result = $urandom;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'($urandom); mem_fwd_value = $urandom;
        wb_we = 1'b1; wb_addr = 5'($urandom); wb_value = $urandom;
        ex_stall = 1'($urandom); flush = 1'($urandom);
        #2;
        chk_reset("reset0");
        @(posedge clk);
        #1;
        reset = 1'b0;
        fwd_off();

        // ADD x5 <- x1, x2 from the register file.
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 32'h11, 32'h100, 16'hAAAA);
        rf_rs1_data = 32'h10; rf_rs2_data = 32'h20;
        comb(1'b0);
        push_cap(32'h10, 32'h20);
        tick("add");

        // Dependent on x5: EX bypass beats MEM/WB/RF, rs2=x0 reads 0.
        drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 32'h22, 32'h104, 16'h0001);
        ex_alu_result = 32'h1234; rf_rs1_data = 32'h5555; rf_rs2_data = 32'h77;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_value = 32'h9999;
        wb_we = 1'b1; wb_addr = 5'd5; wb_value = 32'h8888;
        comb(1'b0);
        push_cap(32'h1234, 32'h0);
        tick("ex_bypass");
        fwd_off();

        // LW x7.
        drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'h4, 32'h108, 16'h0002);
        rf_rs1_data = 32'h2000; ex_alu_result = 32'h1;
        comb(1'b0);
        push_cap(32'h2000, 32'h0);
        tick("lw");
        fwd_off();

        // Dependent on x7 via rs2: one bubble.
        drv(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h8, 32'h10C, 16'h0003);
        ex_alu_result = 32'h3333;
        comb(1'b1);
        push_bubble();
        tick("lu_bubble");

        // Same instruction again: the load is in MEM now.
        ex_alu_result = 32'h0;
        rf_rs1_data = 32'h111; rf_rs2_data = 32'h0;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_value = 32'hDEADBEEF;
        comb(1'b0);
        push_cap(32'h111, 32'hDEADBEEF);
        tick("lu_mem_fwd");
        fwd_off();

        // WB write-through over a stale register file value; writes x0.
        drv(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 32'hC, 32'h110, 16'h0004);
        rf_rs1_data = 32'h0;
        wb_we = 1'b1; wb_addr = 5'd3; wb_value = 32'hA5A5A5A5;
        comb(1'b0);
        push_cap(32'hA5A5A5A5, 32'h0);
        tick("wb_bypass");
        fwd_off();

        // All bypass sources target x0: operands stay 0. Next is LW x7.
        drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 32'h10, 32'h114, 16'h0005);
        ex_alu_result = 32'hFFFFFFFF;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_value = 32'hBBBB;
        wb_we = 1'b1; wb_addr = 5'd0; wb_value = 32'hCCCC;
        rf_rs1_data = 32'h1111; rf_rs2_data = 32'h2222;
        comb(1'b0);
        push_cap(32'h0, 32'h0);
        tick("x0");
        fwd_off();

        // Load-use together with flush: flush wins, no count, no stall.
        drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 32'h12, 32'h118, 16'h0007);
        flush = 1'b1;
        comb(1'b0);
        push_flush();
        tick("flush_lu");
        fwd_off();

        // LW x7 again.
        drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h14, 32'h11C, 16'h0006);
        comb(1'b0);
        push_cap(32'h0, 32'h0);
        tick("lw2");

        // ex_stall with a pending load-use: hold for three cycles, no count.
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 32'h100 + 32'(i), 32'h120, 16'h0008);
            ex_stall = 1'b1;
            comb(1'b1);
            push_hold();
            tick("stall_hold");
        end
        ex_stall = 1'b0;
        comb(1'b1);
        push_bubble();
        tick("lu_bubble2");
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_value = 32'h0BADF00D;
        comb(1'b0);
        push_cap(32'h0BADF00D, 32'h0);
        tick("lu_mem_fwd2");
        fwd_off();

        // Repeated load-use pairs: the 2-bit counter saturates at 3.
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h200, 32'h200 + 32'(8 * k), 16'h0010);
            comb(1'b0);
            push_cap(32'h0, 32'h0);
            tick("sat_lw");
            drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 32'h300, 32'h204 + 32'(8 * k), 16'h0011);
            comb(1'b1);
            push_bubble();
            tick("sat_bubble");
            mem_fwd_we = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_value = 32'hC0DE0000 + 32'(k);
            comb(1'b0);
            push_cap(32'hC0DE0000 + 32'(k), 32'h0);
            tick("sat_fwd");
            fwd_off();
        end

        // Reset in the middle of a stall discards the held instruction.
        drv(1'b1, 5'd4, 5'd6, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'h44, 32'h400, 16'h0020);
        rf_rs1_data = 32'h4444; rf_rs2_data = 32'h6666;
        comb(1'b0);
        push_cap(32'h4444, 32'h6666);
        tick("pre_rst");
        ex_stall = 1'b1;
        comb(1'b1);
        push_hold();
        tick("pre_rst_hold");
        #1;
        reset = 1'b1;
        #1;
        chk_reset("reset_mid");
        m_cnt = '0; m_cnt2 = '0;
        reset = 1'b0;
        fwd_off();
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 32'h55, 32'h500, 16'h0030);
        rf_rs1_data = 32'h5151; rf_rs2_data = 32'h5252;
        comb(1'b0);
        push_cap(32'h5151, 32'h5252);
        tick("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit in case the stimulus ever stalls.
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

ID/EX boundary stage of the RV32I pipeline. Drives the register file read ports from the decoded instruction and resolves each operand by bypass priority: EX, then MEM, then WB, then register file. It detects load-use hazards and inserts a one-cycle bubble. It registers the resolved operands and control into the EX stage, with stall, flush and a saturating load-use event counter.

## Interface

Parameters:
- CNT_W, 16, width of load-use stall counter

Ports (clock and reset first). Clock is `clk`; reset is `reset`, asynchronous and active-high.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registered state
- id_valid  in  1  decode holds a valid instruction
- id_rs1_addr, id_rs2_addr  in  5 each  source register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rd_addr  in  5  destination index
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_imm  in  32  decoded immediate
- id_pc  in  32  instruction PC
- id_ctrl  in  16  opaque EX/MEM/WB control, passed through
- rf_rs1_addr, rf_rs2_addr  out  5 each  register file read addresses, combinationally equal to id_rs1_addr / id_rs2_addr
- rf_rs1_data, rf_rs2_data  in  32 each  register file read data (asynchronous read)
- ex_alu_result  in  32  EX-stage result for the instruction currently in this block's output register
- mem_fwd_we  in  1  MEM-stage instruction writes rd; value is ready, including load data
- mem_fwd_rd  in  5  MEM-stage rd
- mem_fwd_value  in  32  MEM-stage result
- wb_we, wb_addr, wb_value  in  1/5/32  same signals driven to the register file write port this cycle
- ex_stall  in  1  downstream holds EX
- flush  in  1  kill the EX-bound instruction (taken branch/jump resolved in EX)
- id_stall  out  1  decode/fetch must hold (combinational)
- ex_valid  out  1  registered valid
- ex_rs1_value, ex_rs2_value  out  32 each  resolved operands
- ex_rd_addr  out  5  registered rd
- ex_rd_we  out  1  registered rd write enable
- ex_is_load  out  1  registered load flag
- ex_imm, ex_pc  out  32 each  registered immediate and PC
- ex_ctrl  out  16  registered control
- load_use_cnt  out  CNT_W  count of inserted load-use bubbles, saturating

## Operation

- Operand resolution (per source, independently; rsN = id_rsN_addr):
  - rsN==0 → 0, regardless of any bypass match.
  - Else if ex_valid & ex_rd_we & !ex_is_load & ex_rd_addr==rsN → ex_alu_result.
  - Else if mem_fwd_we & mem_fwd_rd==rsN → mem_fwd_value.
  - Else if wb_we & wb_addr==rsN → wb_value. This covers same-cycle write-through, because the register file updates only at the edge.
  - Else → rf_rsN_data.
- load_use = id_valid & ex_valid & ex_is_load & ex_rd_we & ex_rd_addr!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
- id_stall = (load_use | ex_stall) & !flush.
- Output register update at each edge, in priority order:
  1. flush → ex_valid, ex_rd_we, ex_is_load ← 0; the other fields are don't-care.
  2. ex_stall → hold all outputs.
  3. load_use → bubble: ex_valid, ex_rd_we, ex_is_load ← 0. load_use_cnt increments, saturating at all-ones.
  4. Otherwise capture: ex_valid←id_valid, ex_rd_we←id_rd_we & id_valid, ex_is_load←id_is_load & id_valid, resolved operands, and all pass-through fields.
- The counter does not increment under flush or ex_stall.

## Timing

- Reset: all outputs 0, including ex_valid=0 and load_use_cnt=0. Reset takes effect immediately, with no clock needed. Reset mid-stall discards the held instruction.
- Latency: one cycle from ID inputs to ex_* outputs.
- rf_rs*_addr and id_stall are combinational, with no registered delay.
- A load-use dependency costs exactly one bubble. On the next cycle the load is in MEM, load_use deasserts, and the operand comes from mem_fwd_value.
- Back-to-back ALU dependency incurs zero stall, via the EX bypass.
- Simultaneous flush and load_use: flush wins, no bubble is counted, and id_stall=0.
- Simultaneous ex_stall and load_use: hold, no counter increment, id_stall=1.

## Test plan

- Reset asserted with random inputs → all ex_* and load_use_cnt read 0 immediately. After release, the first captured instruction appears one edge later.
- ADD x5 in EX with ex_alu_result=0x1234, dependent in ID with rs1=5 → ex_rs1_value=0x1234 next cycle, id_stall=0.
- LW x7 in EX, dependent uses rs2=7:
  - Cycle 1: id_stall=1, bubble issued (ex_valid=0), load_use_cnt=1.
  - Cycle 2: mem_fwd_value=0xDEADBEEF → ex_rs2_value=0xDEADBEEF.
- wb_we=1, wb_addr=3, wb_value=0xA5A5A5A5, rf_rs1_data=0 stale, rs1=3 → ex_rs1_value=0xA5A5A5A5. With rs1=0 and all bypasses matching x0 → 0.
- Load-use condition with flush=1 in the same cycle → ex_valid=0, id_stall=0, load_use_cnt unchanged.
- ex_stall=1 for 3 cycles with a valid instruction captured → outputs held constant and id_stall=1 throughout. With CNT_W=2 forced to 3, a further load-use leaves the counter at 3.
